// File: rtl/multi_cycle_mdu.sv
// Iterative multiply/divide unit (MULT/DIV/MADD/MSUB families) behind a start/busy/done handshake.
// Define MDU_ITER_MUL_EN to use a WIDTH-iteration shift-add multiplier instead of a one-cycle one.
module multi_cycle_mdu #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   op1,
  input  logic [WIDTH-1:0]   op2,
  input  logic [2*WIDTH-1:0] hilo_i,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] result,
  output logic               div0
);

  localparam int unsigned CntW = $clog2(WIDTH + 2);
`ifdef MDU_ITER_MUL_EN
  localparam int unsigned IdxW = $clog2(WIDTH);
  localparam logic [CntW-1:0] MulLast = CntW'(WIDTH);
`else
  localparam logic [CntW-1:0] MulLast = CntW'(1);
`endif
  localparam logic [CntW-1:0] DivLast = CntW'(WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StMul, StDiv, StAcc, StDone} state_e;

  state_e             r_state;
  state_e             w_state_nxt;
  logic [CntW-1:0]    r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_op1;
  logic [WIDTH-1:0]   r_op2;
  logic [2*WIDTH-1:0] r_hilo;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [2*WIDTH-1:0] r_result;
  logic               r_div0;

  logic               w_accept;
  logic               w_signed;
  logic               w_neg1;
  logic               w_neg2;
  logic [WIDTH-1:0]   w_abs1;
  logic [WIDTH-1:0]   w_abs2;
  logic [2*WIDTH-1:0] w_mul_step;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [2*WIDTH-1:0] w_acc_res;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH-1:0]   w_sub;
  logic               w_fits;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;
  logic [2*WIDTH-1:0] w_div_res;

  // op[0]=1 selects the unsigned variant for every op family.
  assign w_signed = ~r_op[0];
  assign w_neg1   = w_signed & r_op1[WIDTH-1];
  assign w_neg2   = w_signed & r_op2[WIDTH-1];
  assign w_abs1   = w_neg1 ? -r_op1 : r_op1;
  assign w_abs2   = w_neg2 ? -r_op2 : r_op2;

`ifdef MDU_ITER_MUL_EN
  logic [IdxW-1:0]    w_idx;
  logic [2*WIDTH-1:0] w_partial;
  assign w_idx      = r_cnt[IdxW-1:0];
  assign w_partial  = w_abs2[w_idx] ? ({{WIDTH{1'b0}}, w_abs1} << w_idx) : '0;
  assign w_mul_step = r_acc + w_partial;
`else
  assign w_mul_step = {{WIDTH{1'b0}}, w_abs1} * {{WIDTH{1'b0}}, w_abs2};
`endif

  assign w_prod_fix = (w_neg1 ^ w_neg2) ? -r_acc : r_acc;
  // In ACC r_acc already holds the sign-fixed product.
  assign w_acc_res  = r_op[1] ? (r_hilo - r_acc) : (r_hilo + r_acc);

  // Restoring division step; w_sub is exact whenever w_fits since the remainder stays below 2^WIDTH.
  assign w_shift   = {r_rem, r_quo[WIDTH-1]};
  assign w_fits    = (w_shift >= {1'b0, w_abs2});
  assign w_sub     = w_shift[WIDTH-1:0] - w_abs2;
  assign w_quo_fix = (w_neg1 ^ w_neg2) ? -r_quo : r_quo;
  assign w_rem_fix = w_neg1 ? -r_rem : r_rem;
  assign w_div_res = (r_op2 == '0) ? {r_op1, {WIDTH{1'b1}}} : {w_rem_fix, w_quo_fix};

  assign w_accept = ((r_state == StIdle) || (r_state == StDone)) && start && !flush;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StIdle, StDone: begin
        if (start) begin
          w_state_nxt = (op[1] & ~op[2]) ? StDiv : StMul;
        end else begin
          w_state_nxt = StIdle;
        end
      end
      StMul: begin
        if (r_cnt == MulLast) begin
          w_state_nxt = r_op[2] ? StAcc : StDone;
        end
      end
      StDiv: begin
        if (r_cnt == DivLast) begin
          w_state_nxt = StDone;
        end
      end
      StAcc:   w_state_nxt = StDone;
      default: w_state_nxt = StIdle;
    endcase
    if (flush) begin
      w_state_nxt = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_hilo   <= '0;
      r_acc    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_result <= '0;
      r_div0   <= 1'b0;
    end else if (!flush) begin
      if (w_accept) begin
        r_op   <= op;
        r_op1  <= op1;
        r_op2  <= op2;
        r_hilo <= hilo_i;
        r_cnt  <= '0;
        r_acc  <= '0;
      end else begin
        case (r_state)
          StMul: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == MulLast) begin
              if (r_op[2]) begin
                r_acc <= w_prod_fix;
              end else begin
                r_result <= w_prod_fix;
                r_div0   <= 1'b0;
              end
            end else begin
              r_acc <= w_mul_step;
            end
          end
          StDiv: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == '0) begin
              r_rem <= '0;
              r_quo <= w_abs1;
            end else if (r_cnt == DivLast) begin
              r_result <= w_div_res;
              r_div0   <= (r_op2 == '0);
            end else begin
              r_rem <= w_fits ? w_sub : w_shift[WIDTH-1:0];
              r_quo <= {r_quo[WIDTH-2:0], w_fits};
            end
          end
          StAcc: begin
            r_result <= w_acc_res;
            r_div0   <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign busy   = (r_state == StMul) || (r_state == StDiv) || (r_state == StAcc);
  assign done   = (r_state == StDone);
  assign result = r_result;
  assign div0   = r_div0;

endmodule

// File: tb/tb_multi_cycle_mdu.sv
// Directed self-checking bench for multi_cycle_mdu (WIDTH=32); latency follows MDU_ITER_MUL_EN.
module tb_multi_cycle_mdu;

`ifdef MDU_ITER_MUL_EN
  localparam int NMul = 33;
`else
  localparam int NMul = 2;
`endif
  localparam int NDiv = 34;

  localparam logic [2:0] OpMult  = 3'b000;
  localparam logic [2:0] OpMultu = 3'b001;
  localparam logic [2:0] OpDiv   = 3'b010;
  localparam logic [2:0] OpDivu  = 3'b011;
  localparam logic [2:0] OpMadd  = 3'b100;
  localparam logic [2:0] OpMsub  = 3'b110;
  localparam logic [2:0] OpMsubu = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        start;
  logic [2:0]  op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [63:0] hilo_i;
  logic        busy;
  logic        done;
  logic [63:0] result;
  logic        div0;

  int n_cmp;
  int n_fail;

  multi_cycle_mdu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (flush),
    .start  (start),
    .op     (op),
    .op1    (op1),
    .op2    (op2),
    .hilo_i (hilo_i),
    .busy   (busy),
    .done   (done),
    .result (result),
    .div0   (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Ends #1 after the start edge with inputs scrambled so latching is exercised.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] h);
    @(negedge clk);
    start = 1'b1; op = o; op1 = a; op2 = b; hilo_i = h;
    @(posedge clk);
    #1;
    start = 1'b0; op = ~o; op1 = ~a; op2 = ~b; hilo_i = ~h;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    bit seen;
    n_cmp = 0; n_fail = 0;
    rst_n = 1'b0; flush = 1'b0; start = 1'b0; op = '0; op1 = '0; op2 = '0; hilo_i = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_div0", {63'b0, div0}, 64'd0);
    chk("rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OpMult, 32'hFFFF_FFFE, 32'd3, 64'd0);
    wait_done(lat);
    chk("mult_res", result, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("mult_lat", 64'(lat), 64'(NMul));
    chk("mult_busy_in_done", {63'b0, busy}, 64'd0);

    issue(OpMultu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0);
    wait_done(lat);
    chk("multu_res", result, 64'hFFFF_FFFE_0000_0001);
    chk("multu_lat_b2b", 64'(lat), 64'(NMul));
    @(posedge clk);
    #1;
    chk("done_one_cycle", {63'b0, done}, 64'd0);
    chk("idle_busy", {63'b0, busy}, 64'd0);
    chk("result_held", result, 64'hFFFF_FFFE_0000_0001);

    issue(OpDivu, 32'd100, 32'd7, 64'd0);
    wait_done(lat);
    chk("divu_res", result, {32'h0000_0002, 32'h0000_000E});
    chk("divu_lat", 64'(lat), 64'(NDiv));
    chk("divu_div0", {63'b0, div0}, 64'd0);

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 64'd0);
    wait_done(lat);
    chk("div_neg_res", result, {32'hFFFF_FFFF, 32'hFFFF_FFFD});

    issue(OpDivu, 32'h0000_1234, 32'd0, 64'd0);
    wait_done(lat);
    chk("div0_flag", {63'b0, div0}, 64'd1);
    chk("div0_res", result, {32'h0000_1234, 32'hFFFF_FFFF});
    chk("div0_lat", 64'(lat), 64'(NDiv));

    issue(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, 64'd0);
    wait_done(lat);
    chk("divmin_res", result, {32'h0000_0000, 32'h8000_0000});
    chk("divmin_div0", {63'b0, div0}, 64'd0);

    issue(OpMsubu, 32'd1, 32'd1, 64'd0);
    wait_done(lat);
    chk("msubu_res", result, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("msubu_lat", 64'(lat), 64'(NMul + 1));

    issue(OpMadd, 32'hFFFF_FFFF, 32'd2, 64'd5);
    wait_done(lat);
    chk("madd_res", result, 64'h0000_0000_0000_0003);

    issue(OpMsub, 32'd3, 32'hFFFF_FFFE, 64'h10);
    wait_done(lat);
    chk("msub_res", result, 64'h0000_0000_0000_0016);

    // start held during the busy window must not disturb or queue anything
    issue(OpDivu, 32'd100, 32'd7, 64'd0);
    start = 1'b1; op = OpMultu; op1 = 32'd6; op2 = 32'd7;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    chk("busy_start_res", result, {32'h0000_0002, 32'h0000_000E});
    chk("busy_start_lat", 64'(lat + 3), 64'(NDiv));
    @(posedge clk);
    #1;
    chk("busy_start_noqueue", {63'b0, busy}, 64'd0);

    issue(OpDiv, 32'hFFFF_FFF9, 32'd2, 64'd0);
    repeat (9) @(posedge clk);
    #1;
    chk("flush_pre_busy", {63'b0, busy}, 64'd1);
    @(negedge clk);
    flush = 1'b1; start = 1'b1; op = OpMultu; op1 = 32'd6; op2 = 32'd7;
    @(posedge clk);
    #1;
    chk("flush_busy", {63'b0, busy}, 64'd0);
    chk("flush_done", {63'b0, done}, 64'd0);
    @(negedge clk);
    flush = 1'b0; start = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    chk("flush_quiet", {63'b0, seen}, 64'd0);
    chk("flush_result", result, {32'h0000_0002, 32'h0000_000E});
    chk("flush_div0", {63'b0, div0}, 64'd0);

    issue(OpDivu, 32'd5, 32'd0, 64'd0);
    wait_done(lat);
    chk("pre_rst_div0", {63'b0, div0}, 64'd1);
    issue(OpDiv, 32'd100, 32'd7, 64'd0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_busy", {63'b0, busy}, 64'd0);
    chk("async_rst_done", {63'b0, done}, 64'd0);
    chk("async_rst_div0", {63'b0, div0}, 64'd0);
    chk("async_rst_result", result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(OpMult, 32'hFFFF_FFFE, 32'd3, 64'd0);
    wait_done(lat);
    chk("post_rst_res", result, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("post_rst_lat", 64'(lat), 64'(NMul));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
